// File: rtl/spi_master.sv
// spi_master: parameterised SPI master for the Hack peripheral bus.
// Shifts one WIDTH-bit word out on mosi while capturing one from miso, and
// presents {busy, received word} in the 16-bit Hack memory-mapped format.
// Optional chip-select generation: define SPI_MASTER_CSN_EN to drive csn,
// otherwise csn is tied high with identical transfer timing.
module spi_master #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [15:0]      out,
  output logic             done,
  output logic             mosi,
  input  logic             miso,
  output logic             sck,
  output logic             csn
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EDGE_W = $clog2(2 * WIDTH);
  localparam logic CPOL_L = (CPOL != 0);
  localparam logic CPHA_L = (CPHA != 0);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [WIDTH-1:0]    tx_q, tx_d;
  logic [WIDTH-1:0]    rx_q, rx_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;

  logic half_end;
  logic last_edge;
  logic accept;
  logic finish;
  logic sample_edge;

  // Bit that goes on the wire next, depending on shift direction.
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // Drop the bit just sent; vacated positions fill with zero.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  // Insert a received bit so the finished word is right-aligned in either order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic b);
    logic [WIDTH-1:0] bv;
    bv = WIDTH'(b);
    return (MSB_FIRST != 0) ? ((v << 1) | bv) : ((v >> 1) | (bv << (WIDTH - 1)));
  endfunction

  assign half_end    = (div_cnt_q == DIV_LAST);
  assign last_edge   = (edge_cnt_q == EDGE_LAST);
  assign accept      = (state_q == IDLE) && load;
  assign finish      = (state_q == TRAIL) && half_end;
  // Even edges are leading; CPHA picks whether leading or trailing edges sample.
  assign sample_edge = (edge_cnt_q[0] == CPHA_L);

  // State, counter and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sck_q      <= CPOL_L;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
    end
  end

  // Next state and phase counters: each of LEAD, every sck half-period and TRAIL lasts DIV cycles.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d    = LEAD;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
        end
      end
      LEAD: begin
        if (half_end) begin
          state_d   = XFER;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      XFER: begin
        if (half_end) begin
          div_cnt_d = '0;
          if (last_edge) begin
            state_d    = TRAIL;
            edge_cnt_d = '0;
          end else begin
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      TRAIL: begin
        if (half_end) begin
          state_d   = IDLE;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        div_cnt_d  = '0;
        edge_cnt_d = '0;
      end
    endcase
  end

  // Outputs and shift registers: latch on accept, toggle/shift/sample per sck edge, publish on finish.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    sck_d  = sck_q;
    mosi_d = mosi_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    data_d = data_q;
    if (accept) begin
      busy_d = 1'b1;
      tx_d   = in;
      rx_d   = '0;
      if (!CPHA_L) begin
        mosi_d = first_bit(in);
      end
    end else if ((state_q == XFER) && half_end) begin
      sck_d = ~sck_q;
      if (sample_edge) begin
        rx_d = shift_in(rx_q, miso);
      end else if (!CPHA_L) begin
        tx_d   = shift_out(tx_q);
        mosi_d = first_bit(shift_out(tx_q));
      end else begin
        mosi_d = first_bit(tx_q);
        tx_d   = shift_out(tx_q);
      end
    end else if (finish) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      data_d = rx_q;
      mosi_d = 1'b0;
    end
  end

`ifdef SPI_MASTER_CSN_EN
  logic csn_q, csn_d;

  // Chip select falls on acceptance and rises together with done.
  always_comb begin
    csn_d = csn_q;
    if (accept) begin
      csn_d = 1'b0;
    end else if (finish) begin
      csn_d = 1'b1;
    end
  end

  // Chip-select register, deasserted by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      csn_q <= 1'b1;
    end else begin
      csn_q <= csn_d;
    end
  end

  assign csn = csn_q;
`else
  assign csn = 1'b1;
`endif

  // Hack bus word: busy in bit 15, received data right-aligned, other bits zero.
  always_comb begin
    out            = '0;
    out[WIDTH-1:0] = data_q;
    out[15]        = busy_q;
  end

  assign done = done_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: three spi_master instances (default mode 0 loopback,
// mode 3 LSB-first against a slave returning 0x3C, 12-bit DIV=1 loopback)
// checked every cycle against a timeline model of the transfer.
`timescale 1ns/1ps
module tb_spi_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #15 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic check_en = 1'b0;

  // Per-instance configuration used by the model.
  int cfg_w    [3] = '{8, 8, 12};
  int cfg_d    [3] = '{4, 4, 1};
  int cfg_cpol [3] = '{0, 1, 0};
  int cfg_cpha [3] = '{0, 1, 0};
  int cfg_msb  [3] = '{1, 0, 1};

`ifdef SPI_MASTER_CSN_EN
  localparam logic CSN_BUSY = 1'b0;
`else
  localparam logic CSN_BUSY = 1'b1;
`endif

  logic        load_a [3];
  logic [15:0] in_a   [3];
  logic [15:0] out_a  [3];
  logic        done_a [3];
  logic        sck_a  [3];
  logic        mosi_a [3];
  logic        csn_a  [3];

  logic        load0, load1, load2;
  logic [7:0]  in0, in1;
  logic [11:0] in2;
  logic [15:0] out0, out1, out2;
  logic        done0, done1, done2;
  logic        sck0, sck1, sck2;
  logic        mosi0, mosi1, mosi2;
  logic        csn0, csn1, csn2;
  logic        miso0, miso2;
  logic        miso1 = 1'b0;

  assign load0 = load_a[0];
  assign load1 = load_a[1];
  assign load2 = load_a[2];
  assign in0 = in_a[0][7:0];
  assign in1 = in_a[1][7:0];
  assign in2 = in_a[2][11:0];
  assign out_a[0] = out0;   assign out_a[1] = out1;   assign out_a[2] = out2;
  assign done_a[0] = done0; assign done_a[1] = done1; assign done_a[2] = done2;
  assign sck_a[0] = sck0;   assign sck_a[1] = sck1;   assign sck_a[2] = sck2;
  assign mosi_a[0] = mosi0; assign mosi_a[1] = mosi1; assign mosi_a[2] = mosi2;
  assign csn_a[0] = csn0;   assign csn_a[1] = csn1;   assign csn_a[2] = csn2;
  assign miso0 = mosi0;
  assign miso2 = mosi2;

  spi_master u_dut0 (
    .clk(clk), .reset(reset), .load(load0), .in(in0), .out(out0), .done(done0),
    .mosi(mosi0), .miso(miso0), .sck(sck0), .csn(csn0)
  );

  spi_master #(.WIDTH(8), .DIV(4), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .reset(reset), .load(load1), .in(in1), .out(out1), .done(done1),
    .mosi(mosi1), .miso(miso1), .sck(sck1), .csn(csn1)
  );

  spi_master #(.WIDTH(12), .DIV(1)) u_dut2 (
    .clk(clk), .reset(reset), .load(load2), .in(in2), .out(out2), .done(done2),
    .mosi(mosi2), .miso(miso2), .sck(sck2), .csn(csn2)
  );

  // Mode-3 slave: presents the next bit of 0x3C, LSB first, on every leading (falling) sck edge.
  logic [7:0] slave_word = 8'h3C;
  int slave_idx = 0;
  always @(negedge sck1) begin
    miso1 = slave_word[slave_idx];
    slave_idx = (slave_idx + 1) % 8;
  end

  // Observers for the directed tests.
  int sck0_rises = 0;
  always @(posedge sck0) sck0_rises++;
  logic mosi1_cap [256];
  int cap_count = 0;
  always @(posedge sck1) begin
    mosi1_cap[cap_count % 256] = mosi1;
    cap_count++;
  end

  // Model state: cycles since acceptance, transmitted word, last published data.
  bit          active_m [3];
  int          t_m      [3];
  logic [15:0] tx_m     [3];
  logic [15:0] data_m   [3];

  function automatic int period(input int k);
    return (2 * cfg_w[k] + 2) * cfg_d[k];
  endfunction

  function automatic logic [15:0] mask(input int k);
    return 16'((1 << cfg_w[k]) - 1);
  endfunction

  function automatic logic [15:0] expected_rx(input int k, input logic [15:0] w);
    return (k == 1) ? 16'h003C : (w & mask(k));
  endfunction

  // Number of sck toggles completed t cycles after acceptance.
  function automatic int toggles(input int k, input int t);
    int n;
    if (t < 2 * cfg_d[k]) return 0;
    n = t / cfg_d[k] - 1;
    return (n > 2 * cfg_w[k]) ? 2 * cfg_w[k] : n;
  endfunction

  // j-th bit on the wire in transmission order.
  function automatic logic bit_at(input int k, input logic [15:0] w, input int j);
    return (cfg_msb[k] != 0) ? w[cfg_w[k] - 1 - j] : w[j];
  endfunction

  function automatic bit model_busy(input int k);
    return active_m[k] && (t_m[k] < period(k));
  endfunction

  // Model advance on every rising clock edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        active_m[k] = 1'b0;
        t_m[k]      = 0;
        data_m[k]   = 16'h0;
      end else if (!model_busy(k) && load_a[k]) begin
        active_m[k] = 1'b1;
        t_m[k]      = 0;
        tx_m[k]     = in_a[k] & mask(k);
      end else if (active_m[k]) begin
        if (t_m[k] >= period(k)) begin
          active_m[k] = 1'b0;
        end else begin
          t_m[k]++;
          if (t_m[k] == period(k)) data_m[k] = expected_rx(k, tx_m[k]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareCycle(input int k);
    int t, n, j;
    logic busy_e, done_e, sck_e, mosi_e, csn_e;
    logic [15:0] out_e;
    t      = t_m[k];
    busy_e = model_busy(k);
    done_e = active_m[k] && (t == period(k));
    n      = busy_e ? toggles(k, t) : 0;
    sck_e  = (cfg_cpol[k] != 0) ^ ((n % 2) == 1);
    mosi_e = 1'b0;
    if (busy_e) begin
      if (cfg_cpha[k] == 0) begin
        j = n / 2;
        if (j < cfg_w[k]) mosi_e = bit_at(k, tx_m[k], j);
      end else begin
        j = (n + 1) / 2;
        if (j > 0) mosi_e = bit_at(k, tx_m[k], j - 1);
      end
    end
    csn_e = busy_e ? CSN_BUSY : 1'b1;
    out_e = data_m[k];
    if (busy_e) out_e[15] = 1'b1;
    checkOutput($sformatf("dut%0d out", k),  out_a[k],         out_e);
    checkOutput($sformatf("dut%0d done", k), 16'(done_a[k]),   16'(done_e));
    checkOutput($sformatf("dut%0d sck", k),  16'(sck_a[k]),    16'(sck_e));
    checkOutput($sformatf("dut%0d mosi", k), 16'(mosi_a[k]),   16'(mosi_e));
    checkOutput($sformatf("dut%0d csn", k),  16'(csn_a[k]),    16'(csn_e));
  endtask

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 3; k++) compareCycle(k);
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input int k, input logic [15:0] word);
    load_a[k] = 1'b1;
    in_a[k]   = word;
    @(negedge clk);
    load_a[k] = 1'b0;
  endtask

  task automatic waitDone(input int k, input int limit, output int cycles);
    cycles = 0;
    while (done_a[k] !== 1'b1 && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    if (done_a[k] !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL dut%0d done timeout: got no done, expected one within %0d cycles", k, limit);
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 5 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, cnt, base, dcnt, k;
    logic [15:0] w;
    logic exp_seq [8];
    exp_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      load_a[i] = 1'b0;
      in_a[i]   = 16'h0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;

    $display("[TB] reset values");
    checkOutput("reset out0", out0, 16'h0000);
    checkOutput("reset out2", out2, 16'h0000);
    checkOutput("reset done0", 16'(done0), 16'h0);
    checkOutput("reset sck0", 16'(sck0), 16'h0);
    checkOutput("reset sck1", 16'(sck1), 16'h1);
    checkOutput("reset mosi0", 16'(mosi0), 16'h0);
    checkOutput("reset csn0", 16'(csn0), 16'h1);

    $display("[TB] mode 0 loopback 0xA5");
    base = sck0_rises;
    applyStimulus(0, 16'h00A5);
    waitDone(0, 200, lat);
    checkOutput("mode0 done latency", 16'(lat), 16'd72);
    checkOutput("mode0 sck rises", 16'(sck0_rises - base), 16'd8);
    checkOutput("mode0 out", out0, 16'h00A5);
    repeat (3) @(negedge clk);

    $display("[TB] mode 3 LSB-first against slave");
    checkOutput("mode3 sck idle", 16'(sck1), 16'h1);
    base = cap_count;
    applyStimulus(1, 16'h0081);
    waitDone(1, 200, lat);
    checkOutput("mode3 sck edges", 16'(cap_count - base), 16'd8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("mode3 mosi bit %0d", i), 16'(mosi1_cap[(base + i) % 256]), 16'(exp_seq[i]));
    checkOutput("mode3 out", out1, 16'h003C);
    checkOutput("mode3 sck idle after", 16'(sck1), 16'h1);
    repeat (2) @(negedge clk);

    $display("[TB] 12-bit DIV=1 loopback");
    applyStimulus(2, 16'h0ABC);
    cnt = 0;
    while (out2[15] === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("w12 busy duration", 16'(cnt), 16'd26);
    checkOutput("w12 out", out2, 16'h0ABC);
    checkOutput("w12 upper bits", 16'(out2[14:12]), 16'h0);
    repeat (2) @(negedge clk);

    $display("[TB] load while busy");
    applyStimulus(0, 16'h0012);
    repeat (9) @(negedge clk);
    load_a[0] = 1'b1;
    in_a[0]   = 16'h00FF;
    @(negedge clk);
    load_a[0] = 1'b0;
    dcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done0 === 1'b1) dcnt++;
    end
    checkOutput("ignored load done count", 16'(dcnt), 16'd1);
    checkOutput("ignored load out", out0, 16'h0012);

    $display("[TB] reset mid-transfer");
    applyStimulus(0, 16'h005A);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort out", out0, 16'h0000);
    checkOutput("abort sck", 16'(sck0), 16'h0);
    checkOutput("abort csn", 16'(csn0), 16'h1);
    checkOutput("abort done", 16'(done0), 16'h0);
    dcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done0 === 1'b1) dcnt++;
    end
    checkOutput("abort no late done", 16'(dcnt), 16'd0);

    $display("[TB] back-to-back load in done cycle");
    applyStimulus(0, 16'h0096);
    waitDone(0, 200, lat);
    checkOutput("b2b busy in done cycle", 16'(out0[15]), 16'h0);
    checkOutput("b2b csn in done cycle", 16'(csn0), 16'h1);
    checkOutput("b2b first data", out0, 16'h0096);
    applyStimulus(0, 16'h0069);
    checkOutput("b2b busy restarts", 16'(out0[15]), 16'h1);
    checkOutput("b2b csn restarts", 16'(csn0), 16'(CSN_BUSY));
    waitDone(0, 200, lat);
    checkOutput("b2b second latency", 16'(lat), 16'd72);
    checkOutput("b2b second data", out0, 16'h0069);

    $display("[TB] randomized transfers");
    for (int it = 0; it < 30; it++) begin
      k = int'($urandom_range(0, 2));
      w = 16'($urandom) & mask(k);
      applyStimulus(k, w);
      cnt = 0;
      while (model_busy(k) && cnt < 500) begin
        load_a[k] = ($urandom_range(0, 7) == 0);
        in_a[k]   = 16'($urandom);
        @(negedge clk);
        cnt++;
      end
      load_a[k] = 1'b0;
      checkOutput($sformatf("rand dut%0d done", k), 16'(done_a[k]), 16'h1);
      checkOutput($sformatf("rand dut%0d data", k), out_a[k], expected_rx(k, w));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
